uart_rx_oversample: RTL and testbench

//   Receive side of the board UART link (8N1, LSB first). Samples FPGA_SERIAL_RX at OVERSAMPLE x baud.

---
 rtl/uart_rx_oversample.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver: oversampled, majority-voted bits, ready/valid byte output
// with framing and overrun pulses.
module uart_rx_oversample #(
   parameter int CLOCK_FREQ = 125_000_000,
   parameter int BAUD_RATE  = 115_200,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       serial_in,
   output logic [7:0] data_out,
   output logic       data_out_valid,
   input  logic       data_out_ready,
   output logic       framing_error,
   output logic       overrun_error,
   output logic       rx_busy
);
   // state     | meaning
   // IDLE      | line idle, waiting for a low rx_s
   // START     | qualifying the start bit by mid-bit vote
   // DATA      | shifting in 8 data bits, LSB first
   // STOP      | voting the stop bit, deliver or flag framing
   // WAIT_IDLE | after a framing error, wait for the line to return high

   localparam int TICK_CNT_MAX = CLOCK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int TW = $clog2(TICK_CNT_MAX);
   localparam int SW = $clog2(OVERSAMPLE);
   localparam int H  = OVERSAMPLE / 2;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CNT_MAX - 1);
   localparam logic [SW-1:0] S_PRE  = SW'(H - 1);
   localparam logic [SW-1:0] S_MID  = SW'(H);
   localparam logic [SW-1:0] S_VOTE = SW'(H + 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

   state_t        state_q, state_d;
   logic          rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [SW-1:0] s_q, s_d;
   logic [2:0]    bit_idx_q, bit_idx_d;
   logic          samp0_q, samp0_d, samp1_q, samp1_d;
   logic [7:0]    shift_q, shift_d;
   logic          deliver_q, deliver_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          framing_q, framing_d;
   logic          overrun_q, overrun_d;
   logic          tick, vote;

   always_comb begin
      state_d    = state_q;
      rx_meta_d  = serial_in;
      rx_s_d     = rx_meta_q;
      tick       = (tick_cnt_q == TICK_LAST);
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      s_d        = s_q;
      bit_idx_d  = bit_idx_q;
      samp0_d    = samp0_q;
      samp1_d    = samp1_q;
      shift_d    = shift_q;
      deliver_d  = 1'b0;
      data_d     = data_q;
      valid_d    = valid_q;
      framing_d  = 1'b0;
      overrun_d  = 1'b0;
      vote = (samp0_q & samp1_q) | (samp0_q & rx_s_q) | (samp1_q & rx_s_q);

      if (tick && s_q == S_PRE) samp0_d = rx_s_q;
      if (tick && s_q == S_MID) samp1_d = rx_s_q;

      case (state_q)
         IDLE: begin
            s_d = '0;
            if (!rx_s_q) begin
               state_d    = START;
               tick_cnt_d = '0;
            end
         end
         START: if (tick) begin
            s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;
            if (s_q == S_VOTE && vote) begin
               state_d = IDLE;
               s_d     = '0;
            end else if (s_q == S_LAST) begin
               state_d   = DATA;
               bit_idx_d = '0;
            end
         end
         DATA: if (tick) begin
            s_d = (s_q == S_LAST) ? '0 : s_q + 1'b1;
            if (s_q == S_VOTE) shift_d = {vote, shift_q[7:1]};
            if (s_q == S_LAST) begin
               if (bit_idx_q == 3'd7) state_d = STOP;
               else                   bit_idx_d = bit_idx_q + 1'b1;
            end
         end
         STOP: if (tick) begin
            s_d = s_q + 1'b1;
            if (s_q == S_VOTE) begin
               s_d = '0;
               if (vote) begin
                  // Leave at mid-stop so a back-to-back start edge is not missed.
                  state_d   = IDLE;
                  deliver_d = 1'b1;
               end else begin
                  state_d   = WAIT_IDLE;
                  framing_d = 1'b1;
               end
            end
         end
         WAIT_IDLE: begin
            s_d = '0;
            if (rx_s_q) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (valid_q && data_out_ready) valid_d = 1'b0;
      if (deliver_q) begin
         if (!valid_q || data_out_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rx_meta_q  <= 1'b1;
         rx_s_q     <= 1'b1;
         tick_cnt_q <= '0;
         s_q        <= '0;
         bit_idx_q  <= '0;
         samp0_q    <= 1'b0;
         samp1_q    <= 1'b0;
         shift_q    <= '0;
         deliver_q  <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         framing_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rx_meta_q  <= rx_meta_d;
         rx_s_q     <= rx_s_d;
         tick_cnt_q <= tick_cnt_d;
         s_q        <= s_d;
         bit_idx_q  <= bit_idx_d;
         samp0_q    <= samp0_d;
         samp1_q    <= samp1_d;
         shift_q    <= shift_d;
         deliver_q  <= deliver_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
         framing_q  <= framing_d;
         overrun_q  <= overrun_d;
      end
   end

   assign data_out       = data_q;
   assign data_out_valid = valid_q;
   assign framing_error  = framing_q;
   assign overrun_error  = overrun_q;
   assign rx_busy        = (state_q == START) || (state_q == DATA) || (state_q == STOP);

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: directed scenarios plus random frames checked
// against a frame-level model of delivered bytes and error pulses.
module tb_uart_rx_oversample;
   localparam int CF   = 9_216_000;
   localparam int BR   = 115_200;
   localparam int OS   = 16;
   localparam int TICK = CF / (BR * OS);
   localparam int T    = TICK * OS;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       serial_in = 1'b1;
   logic       data_out_ready = 1'b0;
   logic [7:0] data_out;
   logic       data_out_valid, framing_error, overrun_error, rx_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_rx_oversample #(.CLOCK_FREQ(CF), .BAUD_RATE(BR), .OVERSAMPLE(OS)) dut (
      .clk(clk), .rst_n(rst_n), .serial_in(serial_in),
      .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
      .framing_error(framing_error), .overrun_error(overrun_error), .rx_busy(rx_busy)
   );

   // Monitor: transfers, pulse counts and widths, observed mid-cycle.
   logic [7:0] got_q[$];
   int fe_cnt = 0, ov_cnt = 0, valid_cyc = 0, busy_cyc = 0, pulse_long = 0;
   logic fe_prev = 1'b0, ov_prev = 1'b0;
   always @(negedge clk) begin
      if (rst_n) begin
         if (data_out_valid && data_out_ready) got_q.push_back(data_out);
         if (data_out_valid) valid_cyc++;
         if (rx_busy) busy_cyc++;
         if (framing_error && !fe_prev) fe_cnt++;
         if (overrun_error && !ov_prev) ov_cnt++;
         if ((framing_error && fe_prev) || (overrun_error && ov_prev)) pulse_long++;
      end
      fe_prev = framing_error;
      ov_prev = overrun_error;
   end

   // Frame-level reference model.
   logic [7:0] exp_q[$];
   int exp_fe = 0, exp_ov = 0;
   logic m_full = 1'b0, m_ready = 1'b0;
   logic [7:0] m_data = 8'h00;

   task automatic model_frame(input logic [7:0] b, input logic ok);
      if (!ok)            exp_fe++;
      else if (m_ready)   exp_q.push_back(b);
      else if (!m_full) begin m_full = 1'b1; m_data = b; end
      else                exp_ov++;
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1 data_out_ready = v;
      m_ready = v;
      if (v && m_full) begin exp_q.push_back(m_data); m_full = 1'b0; end
      @(negedge clk);
   endtask

   task automatic drive_bit(input logic v, input int spike);
      for (int c = 0; c < T; c++) begin
         serial_in = (c == spike) ? ~v : v;
         @(negedge clk);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v, input int spike);
      drive_bit(1'b0, -1);
      for (int i = 0; i < 8; i++) drive_bit(b[i], spike);
      drive_bit(stop_v, -1);
      serial_in = 1'b1;
      model_frame(b, stop_v);
   endtask

   task automatic idle(input int n);
      serial_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data_out); end
      checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", data_out_valid); end
      checks++; if (framing_error !== 1'b0) begin errors++; $display("FAIL reset_fe: got %b expected 0", framing_error); end
      checks++; if (overrun_error !== 1'b0) begin errors++; $display("FAIL reset_ov: got %b expected 0", overrun_error); end
      checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
      rst_n = 1'b1;
      idle(2 * T);
   endtask

   task automatic test_single_byte;
      int base, vbase, lat;
      set_ready(1'b1);
      base = got_q.size(); vbase = valid_cyc; lat = -1;
      fork
         send_frame(8'h41, 1'b1, -1);
         for (int i = 0; i < 11 * T; i++) begin
            @(negedge clk);
            if (data_out_valid && lat < 0) lat = i;
         end
      join
      checks++; if (!(lat >= 9 * T && lat <= 10 * T)) begin errors++; $display("FAIL single_latency: got %0d cycles expected %0d..%0d", lat, 9 * T, 10 * T); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL single_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      else if (got_q[base] !== exp_q[base]) begin errors++; $display("FAIL single_data: got %h expected %h", got_q[base], exp_q[base]); end
      checks++; if (valid_cyc - vbase != 1) begin errors++; $display("FAIL single_valid_width: got %0d expected 1", valid_cyc - vbase); end
      checks++; if (fe_cnt != exp_fe || ov_cnt != exp_ov) begin errors++; $display("FAIL single_errors: got fe=%0d ov=%0d expected fe=%0d ov=%0d", fe_cnt, ov_cnt, exp_fe, exp_ov); end
   endtask

   task automatic test_back_to_back;
      int base;
      set_ready(1'b0);
      base = got_q.size();
      send_frame(8'h61, 1'b1, -1);
      send_frame(8'h64, 1'b1, -1);
      idle(T);
      checks++; if (data_out_valid !== 1'b1 || data_out !== m_data) begin errors++; $display("FAIL b2b_hold: got v=%b d=%h expected v=1 d=%h", data_out_valid, data_out, m_data); end
      checks++; if (ov_cnt != exp_ov) begin errors++; $display("FAIL b2b_overrun: got %0d expected %0d", ov_cnt, exp_ov); end
      checks++; if (got_q.size() != base) begin errors++; $display("FAIL b2b_no_transfer: got %0d expected %0d", got_q.size(), base); end
      set_ready(1'b1);
      idle(2);
      checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b expected 0", data_out_valid); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      else if (got_q[base] !== exp_q[base]) begin errors++; $display("FAIL b2b_data: got %h expected %h", got_q[base], exp_q[base]); end
   endtask

   task automatic test_glitch;
      int bbase, base;
      bbase = busy_cyc; base = got_q.size();
      serial_in = 1'b0;
      repeat (T / 4) @(negedge clk);
      idle(2 * T);
      checks++; if (!(busy_cyc - bbase > 0 && busy_cyc - bbase < T)) begin errors++; $display("FAIL glitch_busy: got %0d cycles expected 1..%0d", busy_cyc - bbase, T - 1); end
      checks++; if (got_q.size() != base || fe_cnt != exp_fe || ov_cnt != exp_ov) begin errors++; $display("FAIL glitch_quiet: got n=%0d fe=%0d ov=%0d expected n=%0d fe=%0d ov=%0d", got_q.size(), fe_cnt, ov_cnt, base, exp_fe, exp_ov); end
   endtask

   task automatic test_framing;
      int base;
      base = got_q.size();
      send_frame(8'h55, 1'b0, -1);
      serial_in = 1'b0;
      repeat (3 * T / 2) @(negedge clk);
      checks++; if (rx_busy !== 1'b0) begin errors++; $display("FAIL frame_busy_wait: got %b expected 0", rx_busy); end
      repeat (3 * T / 2) @(negedge clk);
      idle(T);
      checks++; if (fe_cnt != exp_fe) begin errors++; $display("FAIL frame_fe: got %0d expected %0d", fe_cnt, exp_fe); end
      send_frame(8'h42, 1'b1, -1);
      idle(T);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL frame_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      else if (got_q[base] !== exp_q[base]) begin errors++; $display("FAIL frame_data: got %h expected %h", got_q[base], exp_q[base]); end
   endtask

   task automatic test_reset_mid_frame;
      int base;
      set_ready(1'b0);
      send_frame(8'h11, 1'b1, -1);
      idle(T);
      checks++; if (data_out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b expected 1", data_out_valid); end
      drive_bit(1'b0, -1);
      for (int i = 0; i < 3; i++) drive_bit(1'(8'h3C >> i), -1);
      checks++; if (rx_busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b expected 1", rx_busy); end
      rst_n = 1'b0;
      serial_in = 1'b1;
      m_full = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if ({data_out, data_out_valid, framing_error, overrun_error, rx_busy} !== 12'h000) begin errors++; $display("FAIL rst_mid_outputs: got d=%h v=%b fe=%b ov=%b busy=%b expected all 0", data_out, data_out_valid, framing_error, overrun_error, rx_busy); end
      rst_n = 1'b1;
      idle(2 * T);
      set_ready(1'b1);
      base = got_q.size();
      send_frame(8'h7E, 1'b1, -1);
      idle(T);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rst_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      else if (got_q[base] !== exp_q[base]) begin errors++; $display("FAIL rst_data: got %h expected %h", got_q[base], exp_q[base]); end
   endtask

   task automatic test_noise;
      int base;
      int offs[3] = '{T / 2 + 5, T / 2, T / 2 + 10};
      for (int k = 0; k < 3; k++) begin
         base = got_q.size();
         send_frame(8'hA5, 1'b1, offs[k]);
         idle(T);
         checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL noise_count[%0d]: got %0d expected %0d", k, got_q.size(), exp_q.size()); end
         else if (got_q[base] !== exp_q[base]) begin errors++; $display("FAIL noise_data[%0d]: got %h expected %h", k, got_q[base], exp_q[base]); end
      end
   endtask

   task automatic test_random;
      int base, spike, gap;
      logic [7:0] b;
      logic ok;
      base = got_q.size();
      for (int n = 0; n < 24; n++) begin
         b = 8'($urandom);
         ok = ($urandom_range(0, 4) != 0);
         spike = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, T - 1)) : -1;
         send_frame(b, ok, spike);
         gap = ok ? int'($urandom_range(0, 2)) * (T / 2) : T + int'($urandom_range(0, T));
         idle(gap);
      end
      idle(2 * T);
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
      else for (int i = base; i < exp_q.size(); i++) begin
         checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand_data[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
      end
      checks++; if (fe_cnt != exp_fe || ov_cnt != exp_ov) begin errors++; $display("FAIL rand_errors: got fe=%0d ov=%0d expected fe=%0d ov=%0d", fe_cnt, ov_cnt, exp_fe, exp_ov); end
      checks++; if (pulse_long != 0) begin errors++; $display("FAIL pulse_width: got %0d long pulses expected 0", pulse_long); end
   endtask

   initial begin
      test_reset;
      test_single_byte;
      test_back_to_back;
      test_glitch;
      test_framing;
      test_reset_mid_frame;
      test_noise;
      test_random;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
